// File: rtl/fetch_unit_pkg.sv
// Shared MIPS definitions for the fetch stage: FSM encoding, reset PC and
// instruction field positions.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  localparam logic [1:0] ST_START = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_ISSUE = 2'd3;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  // Branch displacement in bytes: sign-extended word offset shifted left by two.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch unit (master) and memory (slave).
interface fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/fetch_unit_pc_register.sv
// Program counter with its +4 adder and branch-target mux; advances only when
// the held instruction is consumed.
module pc_register
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        i_load,
  input  logic        i_taken,
  input  logic [15:0] i_imm,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4
);

  // Low bits are forced clear once here; every later update adds multiples of 4.
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'd3;

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic [31:0] w_pc_nxt;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_target   = w_pc_plus4 + branch_offset(i_imm);
  assign w_pc_nxt   = i_taken ? w_target : w_pc_plus4;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pc <= RESET_PC_ALIGNED;
    end else if (i_load) begin
      r_pc <= w_pc_nxt;
    end
  end

  assign o_pc       = r_pc;
  assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request, wait for read data, hold the
// instruction for decode until consumed, then advance the PC.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  fetch_unit_if.master imem,
  output logic         instr_valid_o,
  input  logic         instr_ready_i,
  output logic [31:0]  instr_o,
  output logic [5:0]   opcode_o,
  output logic [31:0]  pc_o,
  output logic [31:0]  pc_plus4_o,
  input  logic         branch_eq_i,
  input  logic         branch_ne_i,
  input  logic         zero_i,
  output logic [31:0]  retired_o,
  output logic         err_o
);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_instr;
  logic [31:0] r_retired;
  logic        r_err;
  logic        w_handshake;
  logic        w_rdata_take;
  logic        w_taken;

  assign w_handshake  = (r_state == ST_ISSUE) && instr_ready_i;
  assign w_rdata_take = (r_state == ST_WAIT) && imem.imem_rvalid_i;

  // beq wins when both strobes are raised, so its condition alone decides.
  assign w_taken = branch_eq_i ? zero_i : (branch_ne_i && !zero_i);

  // NOTE: the next-state default prevents a latch on paths that hold state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_START: w_state_nxt = ST_FETCH;
      ST_FETCH: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (imem.imem_rvalid_i) w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (instr_ready_i)      w_state_nxt = ST_FETCH;
      default:  w_state_nxt = ST_START;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= ST_START;
      r_instr   <= '0;
      r_retired <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_rdata_take) r_instr <= imem.imem_rdata_i;
      if (w_handshake)  r_retired <= r_retired + 32'd1;
      if (imem.imem_rvalid_i && (r_state != ST_WAIT)) r_err <= 1'b1;
    end
  end

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .i_load     (w_handshake),
    .i_taken    (w_taken),
    .i_imm      (r_instr[IMM_MSB:IMM_LSB]),
    .o_pc       (pc_o),
    .o_pc_plus4 (pc_plus4_o)
  );

  assign imem.imem_req_o  = (r_state == ST_FETCH);
  assign imem.imem_addr_o = pc_o;
  assign instr_valid_o    = (r_state == ST_ISSUE);
  assign instr_o          = r_instr;
  assign opcode_o         = r_instr[OPCODE_MSB:OPCODE_LSB];
  assign retired_o        = r_retired;
  assign err_o            = r_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit, checked every cycle against a
// transaction-level model of the fetch/issue behaviour.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  typedef enum int {P_START, P_FETCH, P_WAIT, P_ISSUE} phase_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_ready, beq, bne, zero;
  logic        instr_valid, err;
  logic [31:0] instr, pc, pc_plus4, retired;
  logic [5:0]  opcode;
  bit          chk_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_unit_if imem_bus ();

  fetch_unit dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .imem          (imem_bus),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .opcode_o      (opcode),
    .pc_o          (pc),
    .pc_plus4_o    (pc_plus4),
    .branch_eq_i   (beq),
    .branch_ne_i   (bne),
    .zero_i        (zero),
    .retired_o     (retired),
    .err_o         (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  phase_t      m_phase;
  logic [31:0] m_pc, m_instr, m_retired;
  bit          m_err;

  function automatic logic [31:0] next_pc(input logic [31:0] cur, input logic [31:0] ins,
                                          input bit eq, input bit ne, input bit z);
    bit taken;
    int imm;
    if (eq && ne) taken = z;
    else          taken = (eq && z) || (ne && !z);
    imm = $signed(ins[15:0]);
    if (!taken) return cur + 32'd4;
    return cur + 32'd4 + 32'(imm * 4);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase   <= P_START;
      m_pc      <= RST_PC;
      m_instr   <= '0;
      m_retired <= '0;
      m_err     <= 1'b0;
    end else begin
      if (imem_bus.imem_rvalid_i && m_phase != P_WAIT) m_err <= 1'b1;
      case (m_phase)
        P_START: m_phase <= P_FETCH;
        P_FETCH: m_phase <= P_WAIT;
        P_WAIT: if (imem_bus.imem_rvalid_i) begin
          m_instr <= imem_bus.imem_rdata_i;
          m_phase <= P_ISSUE;
        end
        P_ISSUE: if (instr_ready) begin
          m_pc      <= next_pc(m_pc, m_instr, beq, bne, zero);
          m_retired <= m_retired + 32'd1;
          m_phase   <= P_FETCH;
        end
        default: m_phase <= P_START;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_req",    imem_bus.imem_req_o, m_phase == P_FETCH);
      check("imem_addr",   imem_bus.imem_addr_o, m_pc);
      check("instr_valid", instr_valid, m_phase == P_ISSUE);
      check("instr",       instr, m_instr);
      check("opcode",      opcode, m_instr[31:26]);
      check("pc",          pc, m_pc);
      check("pc_plus4",    pc_plus4, m_pc + 32'd4);
      check("retired",     retired, m_retired);
      check("err",         err, m_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    imem_bus.imem_rvalid_i = 1'b0;
    imem_bus.imem_rdata_i  = $urandom;
    instr_ready = 1'b0;
    beq  = 1'b0;
    bne  = 1'b0;
    zero = 1'b0;
  endtask

  task automatic wait_phase(input phase_t p);
    int n = 0;
    while (m_phase != p && n < 10) begin
      tick();
      n++;
    end
    if (m_phase != p) begin
      n_tests++;
      n_fail++;
      $display("FAIL phase_timeout: model phase %0d, wanted %0d", m_phase, p);
    end
  endtask

  // One complete fetch: rvalid after `gap` idle WAIT cycles, `stall` cycles of
  // ready=0 in ISSUE, then the handshake with the given branch inputs.
  task automatic do_instr(input logic [31:0] data, input int gap, input int stall,
                          input bit eq, input bit ne, input bit z);
    idle_inputs();
    wait_phase(P_WAIT);
    repeat (gap) tick();
    imem_bus.imem_rvalid_i = 1'b1;
    imem_bus.imem_rdata_i  = data;
    tick();
    imem_bus.imem_rvalid_i = 1'b0;
    repeat (stall) begin
      beq  = 1'($urandom);
      bne  = 1'($urandom);
      zero = 1'($urandom);
      tick();
    end
    beq = eq; bne = ne; zero = z;
    instr_ready = 1'b1;
    tick();
    idle_inputs();
  endtask

  initial begin
    int hops;
    logic [31:0] off;

    rst_n = 1'b1;
    idle_inputs();
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pc",       pc, 32'h0040_0000);
    check("rst_pc_plus4", pc_plus4, 32'h0040_0004);
    check("rst_req",      imem_bus.imem_req_o, 1'b0);
    check("rst_valid",    instr_valid, 1'b0);
    rst_n = 1'b1;

    // First fetch: rvalid two cycles after the request.
    wait_phase(P_FETCH);
    check("first_req",  imem_bus.imem_req_o, 1'b1);
    check("first_addr", imem_bus.imem_addr_o, 32'h0040_0000);
    tick();
    tick();
    imem_bus.imem_rvalid_i = 1'b1;
    imem_bus.imem_rdata_i  = 32'h2008_0005;
    tick();
    imem_bus.imem_rvalid_i = 1'b0;
    check("first_valid",  instr_valid, 1'b1);
    check("first_opcode", opcode, 6'h08);

    // Decode stall: held instruction must not move, no new request.
    repeat (5) tick();
    check("stall_instr", instr, 32'h2008_0005);
    check("stall_pc",    pc, 32'h0040_0000);
    check("stall_req",   imem_bus.imem_req_o, 1'b0);
    instr_ready = 1'b1;
    tick();
    idle_inputs();
    check("after_stall_req",  imem_bus.imem_req_o, 1'b1);
    check("after_stall_addr", imem_bus.imem_addr_o, 32'h0040_0004);

    // Walk to 0x0040_0010, then a beq with offset -1 taken / not taken.
    repeat (3) do_instr(32'h2108_0001, 0, 0, 0, 0, 0);
    do_instr(32'h1000_FFFF, 0, 0, 1, 0, 1);
    check("beq_taken_addr", imem_bus.imem_addr_o, 32'h0040_0010);
    do_instr(32'h1000_FFFF, 1, 2, 1, 0, 0);
    check("beq_nt_addr", imem_bus.imem_addr_o, 32'h0040_0014);
    do_instr(32'h1000_0004, 0, 0, 1, 1, 0);
    check("eq_priority_addr", imem_bus.imem_addr_o, 32'h0040_0018);

    // Hop backwards with maximal negative bne offsets, then land on 0xFFFF_FFFC.
    hops = 0;
    while (m_pc > 32'h0001_FFF0 && hops < 64) begin
      do_instr(32'h1400_8000, 0, 0, 0, 1, 0);
      hops++;
    end
    off = 32'd0 - (m_pc + 32'd8);
    do_instr({6'h05, 10'h000, off[17:2]}, 0, 0, 0, 1, 0);
    check("land_addr", imem_bus.imem_addr_o, 32'hFFFF_FFFC);
    do_instr(32'h1400_0003, 0, 1, 0, 1, 0);
    check("wrap_addr", imem_bus.imem_addr_o, 32'h0000_000C);

    // Spurious rvalid in FETCH.
    imem_bus.imem_rvalid_i = 1'b1;
    imem_bus.imem_rdata_i  = 32'hDEAD_BEEF;
    tick();
    imem_bus.imem_rvalid_i = 1'b0;
    check("err_set",         err, 1'b1);
    check("err_instr_hold",  instr, 32'h1400_0003);
    do_instr(32'h0000_1111, 1, 0, 0, 0, 0);
    check("err_sticky", err, 1'b1);

    // Reset asserted mid-fetch in WAIT.
    wait_phase(P_WAIT);
    #2 rst_n = 1'b0;
    #1;
    check("wrst_req",     imem_bus.imem_req_o, 1'b0);
    check("wrst_valid",   instr_valid, 1'b0);
    check("wrst_pc",      pc, 32'h0040_0000);
    check("wrst_instr",   instr, 32'h0);
    check("wrst_retired", retired, 32'h0);
    check("wrst_err",     err, 1'b0);
    @(negedge clk);
    imem_bus.imem_rvalid_i = 1'b1;
    imem_bus.imem_rdata_i  = 32'hABCD_0123;
    tick();
    tick();
    idle_inputs();
    rst_n = 1'b1;
    tick();
    check("post_rst_req",     imem_bus.imem_req_o, 1'b1);
    check("post_rst_addr",    imem_bus.imem_addr_o, 32'h0040_0000);
    check("post_rst_retired", retired, 32'h0);
    check("post_rst_instr",   instr, 32'h0);

    // Random traffic, including rvalid/ready outside their phases.
    for (int i = 0; i < 600; i++) begin
      imem_bus.imem_rvalid_i = ($urandom_range(0, 2) == 0);
      imem_bus.imem_rdata_i  = $urandom;
      instr_ready = 1'($urandom);
      beq  = 1'($urandom);
      bne  = 1'($urandom);
      zero = 1'($urandom);
      tick();
    end
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
